// File: rtl/frog_pkg.sv
// Shared definitions for the frog game lanes: spawn FSM states and the LFSR word width.
package frog_pkg;

    localparam int RND_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAR  = 2'd1,
        GAP  = 2'd2
    } lane_state_t;

endpackage

// File: rtl/lane_spawner_tick_div.sv
// Lane step divider: pulses step on every TICK_DIV-th enabled cycle.
module tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic res,
    input  logic enable,
    output logic step
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign step = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || res) begin
            count <= '0;
        end else if (enable) begin
            count <= step ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/lane_spawner.sv
// One traffic lane: spawns two-cell cars with a forced gap, shifts them along, and flags frog hits.
module lane_spawner
    import frog_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               TICK_DIV = 4,
    parameter logic [RND_W-1:0] THRESH   = 10'd256,
    parameter int               MIN_GAP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res,
    input  logic             enable,
    input  logic [RND_W-1:0] rnd,
    input  logic [4:0]       frog_col,
    input  logic             frog_in_lane,
    output logic [WIDTH-1:0] lane,
    output logic             moved,
    output logic             hit
);

    localparam int GW = $clog2(MIN_GAP + 1);

    logic          step;
    lane_state_t   state, state_next;
    logic [GW-1:0] gap_cnt, gap_next;
    logic          spawn_bit;
    logic          cell_hit;

    tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .res   (res),
        .enable(enable),
        .step  (step)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        spawn_bit  = 1'b0;
        state_next = state;
        gap_next   = gap_cnt;
        case (state)
            IDLE: begin
                if (rnd < THRESH) begin
                    spawn_bit  = 1'b1;
                    state_next = CAR;
                end
            end
            CAR: begin
                spawn_bit  = 1'b1;
                gap_next   = GW'(MIN_GAP);
                state_next = GAP;
            end
            GAP: begin
                if (gap_cnt == GW'(1)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Columns beyond the lane never match, which also covers frog_col >= WIDTH.
    always_comb begin
        cell_hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(frog_col) == i) begin
                cell_hit = lane[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || res) begin
            state   <= IDLE;
            gap_cnt <= '0;
            lane    <= '0;
            moved   <= 1'b0;
            hit     <= 1'b0;
        end else begin
            moved <= step;
            hit   <= frog_in_lane & cell_hit;
            if (step) begin
                state   <= state_next;
                gap_cnt <= gap_next;
                lane    <= {lane[WIDTH-2:0], spawn_bit};
            end
        end
    end

endmodule
